ov7670_sccb_config: RTL and testbench

Power-up register sequencer for the OV7670 camera. It walks an external register ROM of {reg_addr, value} pairs and issues one SCCB 3-phase write per entry over an open-drain SIOC/SIOD pair. It supports inline delay entries and an end-of-table sentinel. It raises `done` so the pixel capture path and frame buffer are enabled only after the sensor is configured.

---
 rtl/ov7670_sccb_config.sv | 174 +++++++++++++++++
 tb/tb_ov7670_sccb_config.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_sccb_config.sv
// OV7670 power-up sequencer: walks a {reg,val} ROM and issues
// SCCB 3-phase writes, with inline delay entries and an end sentinel.
module ov7670_sccb_config #(
  parameter int unsigned CLK_FREQ_HZ  = 100000000,
  parameter int unsigned SCCB_FREQ_HZ = 100000,
  parameter logic [7:0]  DEV_ID       = 8'h42,
  parameter int unsigned DELAY_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        sioc,
  output logic        siod_o,
  output logic        siod_oe,
  output logic        busy,
  output logic        done,
  output logic [7:0]  wr_count
);

  localparam int unsigned QRAW = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int unsigned QDIV = (QRAW < 2) ? 2 : QRAW;
  localparam int unsigned DIVW = $clog2(QDIV);
  localparam int unsigned DLYW =
    (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [DIVW-1:0] DIV_TOP = DIVW'(QDIV - 1);
  localparam logic [DLYW-1:0] DLY_TOP = DLYW'(DELAY_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_START, S_BITS,
    S_STOP, S_GAP, S_DELAY, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [4:0]      bit_q, bit_d;
  logic [26:0]     shf_q, shf_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      wrc_q, wrc_d;
  logic [DLYW-1:0] dly_q, dly_d;

  logic timed, qtick, qend, ack_bit;

  assign timed = (state_q == S_START) || (state_q == S_BITS) ||
                 (state_q == S_STOP)  || (state_q == S_GAP);
  assign qtick = timed && (div_q == DIV_TOP);
  assign qend  = qtick && (qtr_q == 2'd3);
  assign ack_bit = (bit_q == 5'd8) || (bit_q == 5'd17) ||
                   (bit_q == 5'd26);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      shf_q   <= '0;
      addr_q  <= '0;
      wrc_q   <= '0;
      dly_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      shf_q   <= shf_d;
      addr_q  <= addr_d;
      wrc_q   <= wrc_d;
      dly_q   <= dly_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = '0;
    qtr_d   = '0;
    bit_d   = bit_q;
    shf_d   = shf_q;
    addr_d  = addr_q;
    wrc_d   = wrc_q;
    dly_d   = dly_q;
    // Divider and quarter index idle at zero outside bus phases
    if (timed) begin
      div_d = qtick ? '0 : div_q + DIVW'(1);
      qtr_d = qtick ? qtr_q + 2'd1 : qtr_q;
    end
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          addr_d  = '0;
          wrc_d   = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        bit_d = '0;
        dly_d = '0;
        if (rom_data == 16'hFFFF) begin
          state_d = S_DONE;
        end else if (rom_data == 16'hFFF0) begin
          state_d = S_DELAY;
        end else begin
          state_d = S_START;
          shf_d = {DEV_ID, 1'b1, rom_data[15:8], 1'b1,
                   rom_data[7:0], 1'b1};
        end
      end
      S_START: if (qend) state_d = S_BITS;
      S_BITS: begin
        if (qend) begin
          shf_d = {shf_q[25:0], 1'b1};
          if (bit_q == 5'd26) state_d = S_STOP;
          else bit_d = bit_q + 5'd1;
        end
      end
      S_STOP: if (qend) state_d = S_GAP;
      S_GAP: begin
        if (qend) begin
          if (wrc_q != 8'hFF) wrc_d = wrc_q + 8'd1;
          if (addr_q == 8'hFF) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = S_FETCH;
          end
        end
      end
      S_DELAY: begin
        dly_d = dly_q + DLYW'(1);
        if (dly_q == DLY_TOP) begin
          if (addr_q == 8'hFF) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus levels are a pure decode of state and quarter
  always_comb begin
    sioc    = 1'b1;
    siod_o  = 1'b1;
    siod_oe = 1'b1;
    case (state_q)
      S_START: begin
        sioc   = (qtr_q != 2'd3);
        siod_o = (qtr_q == 2'd0);
      end
      S_BITS: begin
        sioc    = (qtr_q == 2'd1) || (qtr_q == 2'd2);
        siod_o  = shf_q[26];
        siod_oe = !ack_bit;
      end
      S_STOP: begin
        sioc   = (qtr_q != 2'd0);
        siod_o = qtr_q[1];
      end
      default: ;
    endcase
  end

  assign rom_addr = addr_q;
  assign wr_count = wrc_q;
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Bench for ov7670_sccb_config: SCCB bus decoder feeding a
// scoreboard of expected {id,reg,val} writes.
module tb_ov7670_sccb_config;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn, start_a, start_b;
  logic [7:0]  addr_a, addr_b, wrc_a, wrc_b;
  logic [15:0] data_a, data_b;
  logic        sioc_a, siod_a, oe_a, busy_a, done_a;
  logic        sioc_b, siod_b, oe_b, busy_b, done_b;
  logic [15:0] rom_a [256];
  logic [15:0] rom_b [256];

  always @(posedge clk) data_a <= rom_a[addr_a];
  always @(posedge clk) data_b <= rom_b[addr_b];

  ov7670_sccb_config #(
    .CLK_FREQ_HZ(4000000), .SCCB_FREQ_HZ(100000),
    .DEV_ID(8'h42), .DELAY_CYCLES(500)
  ) u_a (
    .clk(clk), .resetn(resetn), .start(start_a),
    .rom_addr(addr_a), .rom_data(data_a),
    .sioc(sioc_a), .siod_o(siod_a), .siod_oe(oe_a),
    .busy(busy_a), .done(done_a), .wr_count(wrc_a)
  );

  ov7670_sccb_config #(
    .CLK_FREQ_HZ(800000), .SCCB_FREQ_HZ(100000),
    .DEV_ID(8'h42), .DELAY_CYCLES(16)
  ) u_b (
    .clk(clk), .resetn(resetn), .start(start_b),
    .rom_addr(addr_b), .rom_data(data_b),
    .sioc(sioc_b), .siod_o(siod_b), .siod_oe(oe_b),
    .busy(busy_b), .done(done_b), .wr_count(wrc_b)
  );

  int total = 0;
  int bad   = 0;
  logic [23:0] exp_q [$];
  bit sel = 1'b0;
  bit abort_ok = 1'b0;

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Bus monitor: open-drain line resolves to 1 when released
  logic m_sioc, m_d, m_oe, m_line;
  assign m_sioc = sel ? sioc_b : sioc_a;
  assign m_d    = sel ? siod_b : siod_a;
  assign m_oe   = sel ? oe_b : oe_a;
  assign m_line = m_oe ? m_d : 1'b1;

  logic        p_sioc = 1'b1, p_line = 1'b1, in_tx = 1'b0;
  logic [27:0] dv, ov;
  int          nb = 0;

  always @(negedge clk) begin
    if (p_sioc && m_sioc && p_line && !m_line) begin
      in_tx = 1'b1;
      nb = 0;
      dv = '0;
      ov = '0;
    end else if (!p_sioc && m_sioc && in_tx) begin
      nb++;
      dv = {dv[26:0], m_d};
      ov = {ov[26:0], m_oe};
    end else if (p_sioc && m_sioc && !p_line && m_line && in_tx) begin
      in_tx = 1'b0;
      if (nb != 28 && abort_ok) begin
        abort_ok = 1'b0;
      end else begin
        check("data_clocks", nb - 1, 27);
        check("ack_oe", ov[27:1], 27'b111111110111111110111111110);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write got=%0h",
                   {dv[27:20], dv[18:11], dv[9:2]});
        end else begin
          check("write", {dv[27:20], dv[18:11], dv[9:2]},
                exp_q.pop_front());
        end
      end
    end
    p_sioc = m_sioc;
    p_line = m_line;
  end

  task automatic pulse(input bit b);
    @(negedge clk);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input bit b, input int lim, output int cyc);
    cyc = 0;
    while (!(b ? done_b : done_a) && cyc < lim) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= lim) begin
      total++;
      bad++;
      $display("FAIL done_timeout got=%0d exp<%0d", cyc, lim);
    end
  endtask

  task automatic load_a(input logic [15:0] e0, input logic [15:0] e1,
                        input logic [15:0] e2, input logic [15:0] e3);
    for (int i = 0; i < 256; i++) rom_a[i] = 16'hFFFF;
    rom_a[0] = e0;
    rom_a[1] = e1;
    rom_a[2] = e2;
    rom_a[3] = e3;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int k;
    resetn = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    load_a(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 256; i++) rom_b[i] = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_sioc", sioc_a, 1);
    check("rst_siod", siod_a, 1);
    check("rst_oe", oe_a, 1);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_addr", addr_a, 0);
    check("rst_wrc", wrc_a, 0);
    resetn = 1'b1;

    // single write
    load_a(16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    exp_q.push_back(24'h421280);
    pulse(0);
    wait_done(0, 3000, cyc);
    check("t1_latency", cyc, 1204);
    check("t1_wrc", wrc_a, 1);
    check("t1_addr", addr_a, 1);
    check("t1_busy", busy_a, 0);
    check("t1_sb_empty", exp_q.size(), 0);

    // restart from DONE repeats identically
    exp_q.push_back(24'h421280);
    pulse(0);
    check("rs_done_drop", done_a, 0);
    check("rs_busy", busy_a, 1);
    wait_done(0, 3000, cyc);
    check("rs_latency", cyc, 1204);
    check("rs_wrc", wrc_a, 1);
    check("rs_sb_empty", exp_q.size(), 0);

    // delay entry keeps bus idle, not counted
    load_a(16'hFFF0, 16'h1101, 16'hFFFF, 16'hFFFF);
    exp_q.push_back(24'h421101);
    pulse(0);
    k = 0;
    while (sioc_a && (oe_a ? siod_a : 1'b1) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("dly_idle", k, 514);
    wait_done(0, 3000, cyc);
    check("dly_wrc", wrc_a, 1);
    check("dly_addr", addr_a, 2);
    check("dly_sb_empty", exp_q.size(), 0);

    // start ignored while busy
    load_a(16'h1A2B, 16'h3C4D, 16'h5E6F, 16'hFFFF);
    exp_q.push_back(24'h421A2B);
    exp_q.push_back(24'h423C4D);
    exp_q.push_back(24'h425E6F);
    pulse(0);
    repeat (100) @(negedge clk);
    pulse(0);
    wait_done(0, 5000, cyc);
    check("bsy_done", done_a, 1);
    check("bsy_wrc", wrc_a, 3);
    check("bsy_sb_empty", exp_q.size(), 0);

    // reset during bit 10 (quarter 1), then rerun
    load_a(16'hA5C3, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    exp_q.push_back(24'h42A5C3);
    abort_ok = 1'b1;
    pulse(0);
    repeat (455) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check("rm_sioc", sioc_a, 1);
    check("rm_siod", siod_a, 1);
    check("rm_busy", busy_a, 0);
    check("rm_addr", addr_a, 0);
    check("rm_wrc", wrc_a, 0);
    pulse(0);
    wait_done(0, 3000, cyc);
    check("rm_latency", cyc, 1204);
    check("rm_wrc_after", wrc_a, 1);
    check("rm_sb_empty", exp_q.size(), 0);

    // no sentinel: 256 bus writes, counter saturates
    repeat (5) @(negedge clk);
    sel = 1'b1;
    for (int i = 0; i < 256; i++) exp_q.push_back(24'h420000);
    pulse(1);
    wait_done(1, 70000, cyc);
    check("ns_done", done_b, 1);
    check("ns_wrc", wrc_b, 255);
    check("ns_addr", addr_b, 255);
    check("ns_sb_empty", exp_q.size(), 0);
    repeat (20) @(negedge clk);
    check("ns_addr_hold", addr_b, 255);
    check("ns_done_hold", done_b, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
